// File: rtl/intr_handler_pkg.sv
// Shared types and codes for the multi-channel interrupt handshake controller.
// Holds the FSM state encoding, cc_mux/uscite codes and a hold-state helper.
package intr_handler_pkg;

   typedef enum logic [2:0] {
      INIT   = 3'b000,
      WAIT   = 3'b001,
      ENIN   = 3'b010,
      ENIN_W = 3'b011,
      INTR   = 3'b100,
      INTR_1 = 3'b101,
      INTR_W = 3'b110
   } state_t;

   localparam logic [1:0] CC_IDLE = 2'b01;
   localparam logic [1:0] CC_INTR = 2'b10;
   localparam logic [1:0] CC_EN   = 2'b11;

   localparam logic [1:0] US_ACT  = 2'b00;
   localparam logic [1:0] US_IDLE = 2'b01;
   localparam logic [1:0] US_TMO  = 2'b10;
   localparam logic [1:0] US_INTR = 2'b11;

   // States that may self-loop while the granted request stays high.
   function automatic logic is_hold(state_t s);
      return s inside {ENIN, ENIN_W, INTR, INTR_W};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from ptr+1.
// Ports: req (requests), ptr (last winner) -> winner (index), any (|req).
module rr_arbiter #(
   parameter int NUM_CH = 4,
   localparam int CH_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [CH_W-1:0]   winner,
   output logic              any
);

   logic [CH_W-1:0] hi_win;
   logic [CH_W-1:0] lo_win;
   logic            hi_any;
   logic            lo_any;

   // Descending scan leaves the lowest set index in each candidate;
   // the "hi" candidate only considers indices above ptr, giving the wrap.
   always_comb begin
      hi_win = '0;
      lo_win = '0;
      hi_any = 1'b0;
      lo_any = 1'b0;
      for (int j = NUM_CH - 1; j >= 0; j--) begin
         if (req[j]) begin
            lo_win = CH_W'(j);
            lo_any = 1'b1;
            if (j > int'(ptr)) begin
               hi_win = CH_W'(j);
               hi_any = 1'b1;
            end
         end
      end
   end

   assign winner = hi_any ? hi_win : lo_win;
   assign any    = lo_any;

endmodule

// File: rtl/intr_handler_mc.sv
// Multi-channel interrupt handshake FSM with round-robin grant and hold timeout.
// Ports: clock, reset (async high), eql[NUM_CH], cont_eql -> cc_mux, uscite,
// enable_count, ackout, grant_id, grant_valid, timeout_err.
// Build option: define STICKY_ERR_EN to make timeout_err hold until reset.
module intr_handler_mc
   import intr_handler_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int WAIT_MAX = 15,
   localparam int CH_W    = $clog2(NUM_CH),
   localparam int CNT_W   = $clog2(WAIT_MAX + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_CH-1:0] eql,
   input  logic              cont_eql,
   output logic [1:0]        cc_mux,
   output logic [1:0]        uscite,
   output logic              enable_count,
   output logic              ackout,
   output logic [CH_W-1:0]   grant_id,
   output logic              grant_valid,
   output logic              timeout_err
);

   state_t          state;
   logic [CH_W-1:0] sel;
   logic [CH_W-1:0] rr_ptr;
   logic [CNT_W-1:0] cnt;

   logic [CH_W-1:0] win;
   logic            any_req;
   logic            e;
   logic            hold;
   logic            tmo;

   rr_arbiter #(
      .NUM_CH(NUM_CH)
   ) u_arb (
      .req    (eql),
      .ptr    (rr_ptr),
      .winner (win),
      .any    (any_req)
   );

   assign e    = eql[sel];
   assign hold = is_hold(state) && e;
   assign tmo  = (cnt == CNT_W'(WAIT_MAX - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= INIT;
         sel          <= '0;
         rr_ptr       <= CH_W'(NUM_CH - 1);
         cnt          <= '0;
         cc_mux       <= '0;
         uscite       <= '0;
         enable_count <= 1'b0;
         ackout       <= 1'b0;
         grant_id     <= '0;
         grant_valid  <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         ackout       <= !cont_eql;
         enable_count <= !cont_eql;
`ifndef STICKY_ERR_EN
         timeout_err  <= 1'b0;
`endif
         // Every non-hold edge changes state, so clearing here covers it.
         cnt <= (hold && !tmo) ? cnt + CNT_W'(1) : '0;

         if (hold && tmo) begin
            state       <= WAIT;
            uscite      <= US_TMO;
            cc_mux      <= CC_IDLE;
            grant_valid <= 1'b0;
            timeout_err <= 1'b1;
         end else begin
            unique case (state)
               INIT: begin
                  state  <= WAIT;
                  cc_mux <= CC_IDLE;
                  uscite <= US_IDLE;
               end
               WAIT: begin
                  if (any_req) begin
                     sel         <= win;
                     rr_ptr      <= win;
                     grant_id    <= win;
                     grant_valid <= 1'b1;
                     state       <= ENIN;
                     uscite      <= US_ACT;
                     cc_mux      <= CC_EN;
                  end else begin
                     state  <= INTR_1;
                     uscite <= US_IDLE;
                     cc_mux <= CC_INTR;
                  end
               end
               INTR_1: begin
                  if (any_req) begin
                     sel         <= win;
                     rr_ptr      <= win;
                     grant_id    <= win;
                     grant_valid <= 1'b1;
                     state       <= INTR;
                     uscite      <= US_ACT;
                     cc_mux      <= CC_EN;
                  end else begin
                     state       <= WAIT;
                     grant_valid <= 1'b0;
                     uscite      <= US_IDLE;
                     cc_mux      <= CC_IDLE;
                  end
               end
               ENIN: begin
                  if (e) begin
                     uscite <= US_ACT;
                     cc_mux <= CC_EN;
                  end else begin
                     state        <= ENIN_W;
                     uscite       <= US_IDLE;
                     cc_mux       <= CC_IDLE;
                     ackout       <= 1'b1;
                     enable_count <= 1'b1;
                  end
               end
               ENIN_W: begin
                  uscite <= US_IDLE;
                  cc_mux <= CC_IDLE;
                  if (!e) begin
                     state       <= WAIT;
                     grant_valid <= 1'b0;
                  end
               end
               INTR: begin
                  if (e) begin
                     uscite <= US_ACT;
                     cc_mux <= CC_EN;
                  end else begin
                     state  <= INTR_W;
                     uscite <= US_INTR;
                     cc_mux <= CC_INTR;
                  end
               end
               INTR_W: begin
                  if (e) begin
                     uscite <= US_INTR;
                     cc_mux <= CC_INTR;
                  end else begin
                     state       <= WAIT;
                     grant_valid <= 1'b0;
                     uscite      <= US_IDLE;
                     cc_mux      <= CC_IDLE;
                  end
               end
               default: begin
                  state <= INIT;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/intr_handler_mc.md
Name: intr_handler_mc

Overview:
Multi-channel interrupt-handshake controller; the parametrised successor of the single-channel b06 interrupt FSM. Serves NUM_CH request lines (eql) through one shared handshake FSM. Adds a round-robin channel grant and a hold-state timeout abort. Sits between peripheral request lines and the shared counter/mux datapath driven by cc_mux, uscite and enable_count.

Parameters:
NUM_CH, 4, number of request channels (>=2)
WAIT_MAX, 15, max consecutive cycles in any hold state before abort (>=2)
CH_W, $clog2(NUM_CH), localparam, grant index width
CNT_W, $clog2(WAIT_MAX+1), localparam, timeout counter width

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
eql  in  NUM_CH  per-channel request/equality flags
cont_eql  in  1  counter-equal flag
cc_mux  out  2  counter mux select
uscite  out  2  status code
enable_count  out  1  counter enable
ackout  out  1  acknowledge
grant_id  out  CH_W  channel currently being served
grant_valid  out  1  grant_id is meaningful
timeout_err  out  1  hold-state abort indicator

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high and acts immediately.
- Reset values: every output 0, state INIT, sel=0, rr_ptr=NUM_CH-1 (the first search starts at channel 0), cnt=0.
- States and encodings: INIT=000, WAIT=001, ENIN=010, ENIN_W=011, INTR=100, INTR_1=101, INTR_W=110. Any other encoding goes to INIT and outputs hold.
- ackout and enable_count are set to !cont_eql every non-reset cycle, except in the ENIN exit case below.
- Round-robin winner: the first asserted eql bit searching upward (with wrap) from rr_ptr+1.
- Transitions (e = eql[sel]):
  - INIT: always ->WAIT; cc_mux=01, uscite=01.
  - WAIT:
    - If |eql: sel and rr_ptr take the winner; grant_valid=1; ->ENIN; uscite=00, cc_mux=11.
    - Else: ->INTR_1; uscite=01, cc_mux=10.
  - INTR_1:
    - If |eql: grant as in WAIT; ->INTR; uscite=00, cc_mux=11.
    - Else: ->WAIT; uscite=01, cc_mux=01.
  - ENIN:
    - e=1: stay (hold); uscite=00, cc_mux=11.
    - e=0: ->ENIN_W; uscite=01, cc_mux=01, ackout=1 and enable_count=1 regardless of cont_eql.
  - ENIN_W: e=1 stay (hold); else ->WAIT. Both cases uscite=01, cc_mux=01.
  - INTR:
    - e=1: stay (hold); uscite=00, cc_mux=11.
    - e=0: ->INTR_W; uscite=11, cc_mux=10.
  - INTR_W:
    - e=1: stay (hold); uscite=11, cc_mux=10.
    - e=0: ->WAIT; uscite=01, cc_mux=01.
- Every transition into WAIT clears grant_valid. grant_id holds its last value.
- Timeout counter (hold states ENIN, ENIN_W, INTR, INTR_W):
  - cnt clears on every state change.
  - On a hold edge, if cnt==WAIT_MAX-1 the hold is replaced by an abort: ->WAIT, uscite=10, cc_mux=01, grant_valid=0, timeout_err=1.
  - Otherwise cnt increments.
  - Result: at most WAIT_MAX cycles are spent in one hold state.
- timeout_err is a single-cycle pulse (see Optional Feature).
- Other eql bits changing while a channel is granted are ignored. A sel channel dropping is handled by the normal e=0 path.
- Reset mid-operation abandons the grant. No pending state is retained.

Optional Feature:
STICKY_ERR_EN
- Defined: timeout_err is sticky; it stays 1 from the first abort until reset.
- Undefined: timeout_err is 1 only on the cycle following each abort edge.

Decomposition:
- Package intr_handler_pkg holds:
  - the state encoding constants/typedef;
  - cc_mux codes CC_IDLE=01, CC_INTR=10, CC_EN=11;
  - uscite codes US_ACT=00, US_IDLE=01, US_TMO=10, US_INTR=11.
- Sub-module rr_arbiter (parameter NUM_CH): inputs req and ptr, outputs winner and any; purely combinational. The pointer register stays in the parent.

Test Plan:
- Async reset: assert reset between edges mid-INTR -> all outputs 0 with no clock edge. Release; next edge -> cc_mux=01, uscite=01.
- Round-robin: eql=0101 in WAIT -> grant_id=0, ENIN, cc_mux=11. Return to WAIT; eql=0101 -> grant_id=2. Again -> grant_id=0.
- ENIN exit: granted ch1, cont_eql=1, eql[1] 1->0 -> ackout=1, enable_count=1, uscite=01, state ENIN_W. Next cycle with cont_eql=1 -> ackout=0.
- Timeout: WAIT_MAX=15, eql[sel] held 1 after ENIN entry at edge k -> self-loops through edge k+14. Edge k+15 -> WAIT, uscite=10, timeout_err=1. Edge k+16 -> timeout_err=0 (1 with STICKY_ERR_EN).
- Idle: eql=0000 -> WAIT/INTR_1 alternation, cc_mux toggling 10/01, uscite=01, grant_valid=0.
- Interrupt path: eql=1000 from INTR_1 -> INTR, grant_id=3. Drop eql[3] -> INTR_W, uscite=11, cc_mux=10. Then ->WAIT.
